// File: rtl/uart_host_pkg.sv
// Shared constants for the UART host-side bus initiator.
package uart_host_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam int unsigned ST_W     = 2;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WRITE = 2'd1;
  localparam logic [1:0]  ST_READ  = 2'd2;
  localparam logic [1:0]  ST_HOLD  = 2'd3;

  // Last-grant encoding used by the arbiter
  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

  // rx_err bit positions
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned ERR_OVF = 2;
  localparam int unsigned ERR_FRM = 1;
  localparam int unsigned ERR_PAR = 0;

  // Data and holdoff counter widths
  localparam int unsigned DATA_W = 8;
  localparam int unsigned HOLD_W = 4;

endpackage

// File: rtl/uart_host_if.sv
// Host-side initiator for the UART core CPU port: turns a tx stream into
// write strobes and drains received bytes (with error flags) into an rx stream.
module uart_host_if
  import uart_host_pkg::*;
#(
  parameter int unsigned HOLDOFF    = 2,
  parameter bit          READ_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic [ERR_W-1:0]  rx_err,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              CSN,
  output logic              WEN,
  output logic              OEN,
  output logic [DATA_W-1:0] DATA_IN,
  input  logic [DATA_W-1:0] DATA_OUT,
  input  logic              TXRDY,
  input  logic              RXRDY,
  input  logic              PARITY_ERR,
  input  logic              FRAMING_ERR,
  input  logic              OVERFLOW
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              csn_q, csn_d;
  logic              wen_q, wen_d;
  logic              oen_q, oen_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [ERR_W-1:0]  rx_err_q, rx_err_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;

  logic wr_req, rd_req, tie_rd, gnt_wr, gnt_rd;

  // Request qualification and tie-break; both polarities alternate on a tie
  always_comb begin
    wr_req = enable & tx_valid & TXRDY;
    rd_req = enable & RXRDY & ~rx_valid_q;
    if (READ_FIRST) tie_rd = (last_grant_q != GNT_RD);
    else            tie_rd = (last_grant_q == GNT_WR);
    gnt_rd = rd_req & (~wr_req | tie_rd);
    gnt_wr = wr_req & ~gnt_rd;
  end

  // Byte acceptance happens only on an IDLE write grant
  assign tx_ready = aresetn & (state_q == ST_IDLE) & gnt_wr;

  // Next-state, strobe and rx-buffer logic
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_grant_d = last_grant_q;
    csn_d        = 1'b1;
    wen_d        = 1'b1;
    oen_d        = 1'b1;
    data_in_d    = data_in_q;
    rx_data_d    = rx_data_q;
    rx_err_d     = rx_err_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;

    case (state_q)
      ST_IDLE: begin
        if (gnt_wr) begin
          state_d      = ST_WRITE;
          csn_d        = 1'b0;
          wen_d        = 1'b0;
          data_in_d    = tx_data;
          last_grant_d = GNT_WR;
        end else if (gnt_rd) begin
          state_d      = ST_READ;
          csn_d        = 1'b0;
          oen_d        = 1'b0;
          last_grant_d = GNT_RD;
        end
      end
      ST_WRITE: begin
        state_d    = ST_HOLD;
        hold_cnt_d = HOLD_W'(HOLDOFF - 1);
      end
      ST_READ: begin
        // Capture on the edge that ends the strobe; the core clears its flags here
        state_d           = ST_HOLD;
        hold_cnt_d        = HOLD_W'(HOLDOFF - 1);
        rx_data_d         = DATA_OUT;
        rx_err_d[ERR_OVF] = OVERFLOW;
        rx_err_d[ERR_FRM] = FRAMING_ERR;
        rx_err_d[ERR_PAR] = PARITY_ERR;
        rx_valid_d        = 1'b1;
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) state_d    = ST_IDLE;
        else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      last_grant_q <= GNT_WR;
      csn_q        <= 1'b1;
      wen_q        <= 1'b1;
      oen_q        <= 1'b1;
      data_in_q    <= '0;
      rx_data_q    <= '0;
      rx_err_q     <= '0;
      rx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_grant_q <= last_grant_d;
      csn_q        <= csn_d;
      wen_q        <= wen_d;
      oen_q        <= oen_d;
      data_in_q    <= data_in_d;
      rx_data_q    <= rx_data_d;
      rx_err_q     <= rx_err_d;
      rx_valid_q   <= rx_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign CSN      = csn_q;
  assign WEN      = wen_q;
  assign OEN      = oen_q;
  assign DATA_IN  = data_in_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_host_if.sv
// Directed self-checking bench for uart_host_if.
module tb_uart_host_if;

  localparam int H = 2;

  logic       CLK, aresetn, enable;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic [2:0] rx_err;
  logic       rx_valid, rx_ready, busy;
  logic       CSN, WEN, OEN;
  logic [7:0] DATA_IN, DATA_OUT;
  logic       TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW;

  int checks   = 0;
  int failures = 0;

  uart_host_if #(.HOLDOFF(H), .READ_FIRST(1'b1)) dut (
    .CLK(CLK), .aresetn(aresetn), .enable(enable),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .CSN(CSN), .WEN(WEN), .OEN(OEN),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .TXRDY(TXRDY), .RXRDY(RXRDY),
    .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    TXRDY = 1'b0; RXRDY = 1'b0; DATA_OUT = 8'h00;
    PARITY_ERR = 1'b0; FRAMING_ERR = 1'b0; OVERFLOW = 1'b0;
  endtask

  initial begin
    int n, lows, cyc, nstr, gap;
    int kind [4];
    int at   [4];
    logic both_low, seen;

    aresetn = 1'b0; enable = 1'b1;
    idle_inputs();
    tick(); tick();

    // Reset values
    check("rst_csn", 32'(CSN), 32'd1);
    check("rst_wen", 32'(WEN), 32'd1);
    check("rst_oen", 32'(OEN), 32'd1);
    check("rst_data_in", 32'(DATA_IN), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_err", 32'(rx_err), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);

    // Single write of 0xA5
    aresetn = 1'b1;
    tx_valid = 1'b1; tx_data = 8'hA5; TXRDY = 1'b1;
    #1;
    check("wr_tx_ready", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
    #1;
    check("wr_csn", 32'(CSN), 32'd0);
    check("wr_wen", 32'(WEN), 32'd0);
    check("wr_oen", 32'(OEN), 32'd1);
    check("wr_data_in", 32'(DATA_IN), 32'hA5);
    check("wr_tx_ready_off", 32'(tx_ready), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    n = 1; lows = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!busy) break;
      n++;
      if (!WEN) lows++;
    end
    // busy covers the WRITE cycle plus HOLDOFF cycles of HOLD
    check("wr_busy_len", 32'(n), 32'(H + 1));
    check("wr_single_pulse", 32'(lows), 32'd0);
    check("wr_csn_released", 32'(CSN), 32'd1);

    // Read 0x3C with parity error, then backpressure
    TXRDY = 1'b0;
    RXRDY = 1'b1; DATA_OUT = 8'h3C; PARITY_ERR = 1'b1;
    tick();
    check("rd_oen", 32'(OEN), 32'd0);
    check("rd_csn", 32'(CSN), 32'd0);
    check("rd_wen", 32'(WEN), 32'd1);
    check("rd_valid_pre", 32'(rx_valid), 32'd0);
    tick();
    check("rd_oen_off", 32'(OEN), 32'd1);
    check("rd_valid", 32'(rx_valid), 32'd1);
    check("rd_data", 32'(rx_data), 32'h3C);
    check("rd_err", 32'(rx_err), 32'b001);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!OEN) lows++;
    end
    check("bp_no_reads", 32'(lows), 32'd0);
    check("bp_valid_held", 32'(rx_valid), 32'd1);
    check("bp_data_held", 32'(rx_data), 32'h3C);
    check("bp_idle", 32'(busy), 32'd0);

    DATA_OUT = 8'h5A; PARITY_ERR = 1'b0; FRAMING_ERR = 1'b1;
    rx_ready = 1'b1;
    tick();
    check("rd_valid_clr", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!OEN) begin seen = 1'b1; break; end
    end
    check("rd2_strobe_seen", 32'(seen), 32'd1);
    tick();
    check("rd2_data", 32'(rx_data), 32'h5A);
    check("rd2_err", 32'(rx_err), 32'b010);
    RXRDY = 1'b0; FRAMING_ERR = 1'b0; rx_ready = 1'b1;
    tick();
    check("rd2_valid_clr", 32'(rx_valid), 32'd0);
    for (int i = 0; i < 8; i++) tick();

    // Contention from reset: grants alternate R,W,R,W
    aresetn = 1'b0;
    idle_inputs();
    tick();
    aresetn = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h11; TXRDY = 1'b1; RXRDY = 1'b1;
    DATA_OUT = 8'h22; rx_ready = 1'b1;
    cyc = 0; nstr = 0; both_low = 1'b0;
    for (int i = 0; i < 4; i++) begin kind[i] = 0; at[i] = 0; end
    for (int i = 0; i < 60; i++) begin
      tick();
      cyc++;
      if (!WEN && !OEN) both_low = 1'b1;
      if (!OEN && nstr < 4) begin kind[nstr] = 1; at[nstr] = cyc; nstr++; end
      else if (!WEN && nstr < 4) begin kind[nstr] = 2; at[nstr] = cyc; nstr++; end
      if (nstr == 4) break;
    end
    check("ct_count", 32'(nstr), 32'd4);
    check("ct_latency", 32'(at[0]), 32'd1);
    check("ct_g0_read", 32'(kind[0]), 32'd1);
    check("ct_g1_write", 32'(kind[1]), 32'd2);
    check("ct_g2_read", 32'(kind[2]), 32'd1);
    check("ct_g3_write", 32'(kind[3]), 32'd2);
    for (int i = 1; i < 4; i++) begin
      gap = at[i] - at[i-1] - 1;
      check("ct_gap", 32'(gap), 32'(H + 1));
    end
    check("ct_no_overlap", 32'(both_low), 32'd0);

    // Reset while a read strobe is active
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!OEN) begin seen = 1'b1; break; end
    end
    check("mr_strobe_seen", 32'(seen), 32'd1);
    aresetn = 1'b0;
    #1;
    check("mr_oen", 32'(OEN), 32'd1);
    check("mr_csn", 32'(CSN), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    idle_inputs();
    tick();
    aresetn = 1'b1;
    tick();
    check("mr_rx_valid", 32'(rx_valid), 32'd0);
    check("mr_oen_idle", 32'(OEN), 32'd1);

    // enable dropped during a write
    tx_valid = 1'b1; tx_data = 8'h77; TXRDY = 1'b1;
    #1;
    check("en_tx_ready", 32'(tx_ready), 32'd1);
    tick();
    check("en_wen", 32'(WEN), 32'd0);
    check("en_data_in", 32'(DATA_IN), 32'h77);
    enable = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!WEN || !CSN) lows++;
    end
    check("en_no_strobes", 32'(lows), 32'd0);
    check("en_idle", 32'(busy), 32'd0);
    check("en_tx_ready_off", 32'(tx_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
